hilo_mul_unit: RTL and testbench

//  Iterative multiply/accumulate unit with HI/LO registers, in the EX stage beside the ALU.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/mul_shift_add_core.sv | 64 ++++++
 rtl/hilo_mul_unit.sv | 145 ++++++++++++++
 tb/tb_hilo_mul_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the HI/LO multiply unit's state and op-kind encodings.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MADD  = 6'b000000;
    localparam logic [5:0] FN_MSUB  = 6'b000100;
    localparam logic [5:0] FN_MUL   = 6'b000010;

    localparam logic [4:0] ALUOP_MULT  = 5'b00010;
    localparam logic [4:0] ALUOP_MULTU = 5'b01101;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix,
        StCommit
    } mul_state_e;

    // mult and multu share a kind: signedness is resolved when operands are latched.
    typedef enum logic [1:0] {
        KindMult,
        KindMadd,
        KindMsub,
        KindMul
    } mul_kind_e;

endpackage

// File: rtl/mul_shift_add_core.sv
// Unsigned shift-add multiplier datapath: retires BITS_PER_CYCLE multiplier bits per step.
module mul_shift_add_core #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               last_o
);

    localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(N - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = CntInit;
        end else if (step_i) begin
            // Multiplicand walks left as the multiplier walks right, so the low
            // multiplier bits always select the correctly weighted partial sums.
            for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
                if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
            end
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign prod_o = acc_q;
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/hilo_mul_unit.sv
// EX-stage multiply/accumulate unit owning HI/LO: decode, sequencing FSM, sign fix,
// accumulate and commit around an iterative shift-add core.
module hilo_mul_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Flush,
    input  logic [4:0]       ALUOp,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] MulResult,
    output logic             Busy,
    output logic             Done
);

    import mips_pkg::*;

    mul_state_e state_q, state_d;
    mul_kind_e  kind_q, kind_d;
    logic       sign_q, sign_d;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, lo_q, mulres_q;

    logic dec_mult, dec_multu, dec_mthi, dec_mtlo, dec_madd, dec_msub, dec_mul;
    logic accept, launch, commit, signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, prod_fixed;
    logic               core_last;

    always_comb begin
        dec_mult  = (Opcode == OP_SPECIAL)  && (Funct == FN_MULT)  && (ALUOp == ALUOP_MULT);
        dec_multu = (Opcode == OP_SPECIAL)  && (Funct == FN_MULTU) && (ALUOp == ALUOP_MULTU);
        dec_mthi  = (Opcode == OP_SPECIAL)  && (Funct == FN_MTHI);
        dec_mtlo  = (Opcode == OP_SPECIAL)  && (Funct == FN_MTLO);
        dec_madd  = (Opcode == OP_SPECIAL2) && (Funct == FN_MADD);
        dec_msub  = (Opcode == OP_SPECIAL2) && (Funct == FN_MSUB);
        dec_mul   = (Opcode == OP_SPECIAL2) && (Funct == FN_MUL);

        // Flush outranks a same-cycle Start, including the register moves.
        accept = Start && !Flush && (state_q == StIdle);
        launch = accept && (dec_mult || dec_multu || dec_madd || dec_msub || dec_mul);
        commit = (state_q == StCommit) && !Flush;

        signed_op = !dec_multu;
        a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
        b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        sign_d  = sign_q;
        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d = StIter;
                    sign_d  = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                    if (dec_madd)      kind_d = KindMadd;
                    else if (dec_msub) kind_d = KindMsub;
                    else if (dec_mul)  kind_d = KindMul;
                    else               kind_d = KindMult;
                end
            end
            StIter:   if (core_last) state_d = StFix;
            StFix:    state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (Flush) state_d = StIdle;
    end

    always_comb begin
        prod_fixed = sign_q ? -prod : prod;
        acc_d      = acc_q;
        if (state_q == StFix) begin
            unique case (kind_q)
                KindMadd: acc_d = {hi_q, lo_q} + prod_fixed;
                KindMsub: acc_d = {hi_q, lo_q} - prod_fixed;
                default:  acc_d = prod_fixed;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StIdle;
            kind_q  <= KindMult;
            sign_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            mulres_q <= '0;
        end else begin
            if (accept && dec_mthi) hi_q <= A;
            if (accept && dec_mtlo) lo_q <= A;
            if (commit) begin
                if (kind_q == KindMul) begin
                    mulres_q <= acc_q[WIDTH-1:0];
                end else begin
                    hi_q <= acc_q[2*WIDTH-1:WIDTH];
                    lo_q <= acc_q[WIDTH-1:0];
                end
            end
        end
    end

    mul_shift_add_core #(
        .WIDTH         (WIDTH),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_core (
        .clk_i (Clk),
        .rst_ni(Rst),
        .load_i(launch),
        .step_i(state_q == StIter),
        .a_i   (a_mag),
        .b_i   (b_mag),
        .prod_o(prod),
        .last_o(core_last)
    );

    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign MulResult = mulres_q;
    assign Busy      = (state_q != StIdle);
    assign Done      = commit;

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Self-checking bench for hilo_mul_unit against a plain-arithmetic HI/LO model.
module tb_hilo_mul_unit;

    localparam int W   = 32;
    localparam int BPC = 1;
    localparam int N   = W / BPC;

    localparam int K_MULT = 0, K_MULTU = 1, K_MADD = 2, K_MSUB = 3, K_MUL = 4;
    localparam int K_MTHI = 5, K_MTLO = 6;

    logic         Clk = 1'b0, Rst = 1'b0, Start = 1'b0, Flush = 1'b0;
    logic [4:0]   ALUOp = '0;
    logic [5:0]   Opcode = '0, Funct = '0;
    logic [W-1:0] A = '0, B = '0;
    logic [W-1:0] Hi, Lo, MulResult;
    logic         Busy, Done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, m_mulres = '0;

    hilo_mul_unit #(
        .WIDTH(W),
        .BITS_PER_CYCLE(BPC)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Flush(Flush), .ALUOp(ALUOp),
        .Opcode(Opcode), .Funct(Funct), .A(A), .B(B), .Hi(Hi), .Lo(Lo),
        .MulResult(MulResult), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic set_op(input int k);
        case (k)
            K_MULT:  begin Opcode = 6'b000000; Funct = 6'b011000; ALUOp = 5'b00010; end
            K_MULTU: begin Opcode = 6'b000000; Funct = 6'b011001; ALUOp = 5'b01101; end
            K_MADD:  begin Opcode = 6'b011100; Funct = 6'b000000; ALUOp = 5'b00010; end
            K_MSUB:  begin Opcode = 6'b011100; Funct = 6'b000100; ALUOp = 5'b00010; end
            K_MUL:   begin Opcode = 6'b011100; Funct = 6'b000010; ALUOp = 5'b00010; end
            K_MTHI:  begin Opcode = 6'b000000; Funct = 6'b010001; ALUOp = 5'b00000; end
            default: begin Opcode = 6'b000000; Funct = 6'b010011; ALUOp = 5'b00000; end
        endcase
    endtask

    function automatic logic [2*W-1:0] model_prod(input int k, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        if (k == K_MULTU) return {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    function automatic void model_apply(input int k, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        logic [2*W-1:0] p, hl;
        p  = model_prod(k, a, b);
        hl = {m_hi, m_lo};
        case (k)
            K_MULT, K_MULTU: {m_hi, m_lo} = p;
            K_MADD:          {m_hi, m_lo} = hl + p;
            K_MSUB:          {m_hi, m_lo} = hl - p;
            K_MUL:           m_mulres = p[W-1:0];
            K_MTHI:          m_hi = a;
            default:         m_lo = a;
        endcase
    endfunction

    // lat counts clock edges from the Start edge (1) to the first edge after which Done is high.
    task automatic run_mul(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output bit timed_out);
        @(negedge Clk);
        set_op(k); A = a; B = b; Start = 1'b1;
        @(posedge Clk);
        lat = 1;
        @(negedge Clk);
        Start = 1'b0;
        while (Done !== 1'b1 && lat < 4 * N) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        timed_out = (Done !== 1'b1);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic run_move(input int k, input logic [W-1:0] a);
        @(negedge Clk);
        set_op(k); A = a; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        model_apply(k, a, '0);
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({Hi, Lo, MulResult} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h_%h_%h want 0_0_0", Hi, Lo, MulResult);
        end
        n_checks++;
        if ({Busy, Done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0 0", Busy, Done);
        end
        Rst = 1'b1;
        m_hi = '0; m_lo = '0; m_mulres = '0;
        @(negedge Clk);
    endtask

    task automatic test_mult_basic();
        int lat;
        bit to;
        run_mul(K_MULT, 32'hFFFF_FFFF, 32'h0000_0002, lat, to);
        model_apply(K_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        n_checks++;
        if (to || lat != N + 2) begin
            n_fail++;
            $display("FAIL mult_latency: got %0d (timeout=%0b) want %0d", lat, to, N + 2);
        end
        n_checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL mult_neg: got %h_%h want ffffffff_fffffffe", Hi, Lo);
        end
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_commit: got %b want 0", Busy);
        end
        run_mul(K_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, lat, to);
        model_apply(K_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        n_checks++;
        if (to || {Hi, Lo} !== 64'h0000_0001_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL multu: got %h_%h (timeout=%0b) want 00000001_fffffffe", Hi, Lo, to);
        end
    endtask

    task automatic test_accumulate();
        int lat;
        bit to;
        run_move(K_MTLO, 32'd5);
        run_move(K_MTHI, 32'd0);
        n_checks++;
        if ({Hi, Lo} !== 64'h5 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL moves: got %h_%h busy=%b want 00000000_00000005 busy=0", Hi, Lo, Busy);
        end
        run_mul(K_MADD, 32'd3, 32'd4, lat, to);
        model_apply(K_MADD, 32'd3, 32'd4);
        n_checks++;
        if (to || {Hi, Lo} !== 64'h11) begin
            n_fail++;
            $display("FAIL madd: got %h_%h want 00000000_00000011", Hi, Lo);
        end
        run_mul(K_MSUB, 32'd1, 32'd1, lat, to);
        model_apply(K_MSUB, 32'd1, 32'd1);
        n_checks++;
        if (to || {Hi, Lo} !== 64'h10) begin
            n_fail++;
            $display("FAIL msub: got %h_%h want 00000000_00000010", Hi, Lo);
        end
    endtask

    task automatic test_msub_mul();
        int lat;
        bit to;
        run_move(K_MTHI, 32'd0);
        run_move(K_MTLO, 32'd0);
        run_mul(K_MSUB, 32'd1, 32'd1, lat, to);
        model_apply(K_MSUB, 32'd1, 32'd1);
        n_checks++;
        if (to || {Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL msub_wrap: got %h_%h want ffffffff_ffffffff", Hi, Lo);
        end
        run_mul(K_MUL, 32'd7, -32'sd3, lat, to);
        model_apply(K_MUL, 32'd7, -32'sd3);
        n_checks++;
        if (to || MulResult !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mul_result: got %h want ffffffeb", MulResult);
        end
        n_checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL mul_keeps_hilo: got %h_%h want ffffffff_ffffffff", Hi, Lo);
        end
    endtask

    task automatic test_random();
        int lat;
        bit to;
        for (int i = 0; i < 24; i++) begin
            int k;
            logic [W-1:0] a, b;
            k = $urandom_range(0, 6);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
            if (k == K_MTHI || k == K_MTLO) begin
                run_move(k, a);
            end else begin
                run_mul(k, a, b, lat, to);
                model_apply(k, a, b);
                n_checks++;
                if (to || lat != N + 2) begin
                    n_fail++;
                    $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, N + 2);
                end
            end
            n_checks++;
            if ({Hi, Lo, MulResult} !== {m_hi, m_lo, m_mulres}) begin
                n_fail++;
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h_%h want %h_%h_%h",
                         i, k, a, b, Hi, Lo, MulResult, m_hi, m_lo, m_mulres);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        @(negedge Clk);
        set_op(K_MULT); A = a; B = b; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b want 1", Busy);
        end
        dones = 0;
        for (int c = 2; c < 3 * N; c++) begin
            if (c == 10) begin
                set_op(K_MULTU); A = ~a; B = ~b; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk);
            @(negedge Clk);
            if (Done === 1'b1) dones++;
        end
        model_apply(K_MULT, a, b);
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL start_while_busy_dones: got %0d want 1", dones);
        end
        n_checks++;
        if ({Hi, Lo} !== {m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL start_while_busy_result: got %h_%h want %h_%h", Hi, Lo, m_hi, m_lo);
        end

        // Flush mid-iteration: no commit, no Done.
        @(negedge Clk);
        set_op(K_MADD); A = $urandom; B = $urandom; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (19) begin @(posedge Clk); @(negedge Clk); end
        Flush = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Flush = 1'b0;
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: got %b want 0", Busy);
        end
        dones = 0;
        repeat (2 * N) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0 || {Hi, Lo} !== {m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL flush_iter: got dones=%0d %h_%h want dones=0 %h_%h",
                     dones, Hi, Lo, m_hi, m_lo);
        end

        // Flush landing on the commit cycle suppresses the write.
        @(negedge Clk);
        set_op(K_MULT); A = 32'd123; B = 32'd456; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        for (int c = 0; c < 4 * N && Done !== 1'b1; c++) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        Flush = 1'b1;
        #1;
        n_checks++;
        if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_commit_done: got %b want 0", Done);
        end
        @(posedge Clk);
        @(negedge Clk);
        // Start with Flush in idle is dropped, including a register move.
        set_op(K_MTLO); A = ~m_lo; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        n_checks++;
        if ({Hi, Lo} !== {m_hi, m_lo} || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_commit_hilo: got %h_%h busy=%b want %h_%h busy=0",
                     Hi, Lo, Busy, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        run_move(K_MTHI, 32'hA5A5_0001);
        run_move(K_MTLO, 32'h5A5A_0002);
        @(negedge Clk);
        set_op(K_MULT); A = 32'd5; B = 32'd9; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (14) begin @(posedge Clk); @(negedge Clk); end
        Rst = 1'b0;
        #1;
        n_checks++;
        if ({Hi, Lo, MulResult, Busy, Done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h_%h_%h busy=%b done=%b want all 0",
                     Hi, Lo, MulResult, Busy, Done);
        end
        m_hi = '0; m_lo = '0; m_mulres = '0;
        @(negedge Clk);
        Rst = 1'b1;
        run_mul(K_MULT, 32'd6, 32'd7, lat, to);
        model_apply(K_MULT, 32'd6, 32'd7);
        n_checks++;
        if (to || lat != N + 2 || {Hi, Lo} !== 64'h2A) begin
            n_fail++;
            $display("FAIL mult_after_reset: got %h_%h lat=%0d want 00000000_0000002a lat=%0d",
                     Hi, Lo, lat, N + 2);
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_accumulate();
        test_msub_mul();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
